// File: rtl/sort_ctrl_if.sv
// Byte stream handshakes around sort_ctrl: upstream input stream and downstream sorted output stream.
interface sort_ctrl_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/sort_ctrl.sv
// Sequencer for the 8-input combinational byte sorter: load 8 bytes, settle, capture, drain sorted.
// Define SORT_CTRL_DESC_EN to stream the sorted frame largest-first instead of smallest-first.
module sort_ctrl #(
    parameter int SETTLE_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    sort_ctrl_if.slave  sif,
    output logic [63:0] sort_a,
    input  logic [63:0] sort_y,
    output logic        busy,
    output logic [15:0] frame_cnt
);
    localparam int NUM_B = 8;

    typedef enum logic [1:0] {LOAD, SETTLE, DRAIN} state_t;

    state_t                       state, state_nxt;
    logic [2:0]                   wr_idx, rd_idx, rd_sel;
    logic [3:0]                   settle_cnt;
    logic [NUM_B-1:0][7:0]        a_q;
    logic [63:0]                  res;
    logic                         in_acc, out_acc;

    assign sort_a  = a_q;
    assign in_acc  = (state == LOAD)  && sif.in_valid;
    assign out_acc = (state == DRAIN) && sif.out_ready;

`ifdef SORT_CTRL_DESC_EN
    assign rd_sel = 3'd7 - rd_idx;
`else
    assign rd_sel = rd_idx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    // Handshake outputs are pure state decode so ready never depends on valid.
    always_comb begin
        state_nxt     = state;
        sif.in_ready  = 1'b0;
        sif.out_valid = 1'b0;
        sif.out_last  = 1'b0;
        sif.out_data  = 8'd0;
        busy          = 1'b0;
        case (state)
            LOAD: begin
                sif.in_ready = 1'b1;
                if (sif.in_valid && wr_idx == 3'd7) state_nxt = SETTLE;
            end
            SETTLE: begin
                busy = 1'b1;
                if (settle_cnt == 4'd0) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy          = 1'b1;
                sif.out_valid = 1'b1;
                sif.out_last  = (rd_idx == 3'd7);
                sif.out_data  = res[8*rd_sel +: 8];
                if (sif.out_ready && rd_idx == 3'd7) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            wr_idx     <= 3'd0;
            settle_cnt <= 4'd0;
        end else if (in_acc) begin
            for (int b = 0; b < NUM_B; b++)
                if (wr_idx == 3'(b)) a_q[b] <= sif.in_data;
            // wr_idx wraps 7 -> 0 on the final accept, ready for the next frame.
            wr_idx <= wr_idx + 3'd1;
            if (wr_idx == 3'd7) settle_cnt <= 4'(SETTLE_CYC - 1);
        end else if (state == SETTLE && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res       <= '0;
            rd_idx    <= 3'd0;
            frame_cnt <= 16'd0;
        end else if (state == SETTLE && settle_cnt == 4'd0) begin
            res    <= sort_y;
            rd_idx <= 3'd0;
        end else if (out_acc) begin
            rd_idx <= rd_idx + 3'd1;
            if (rd_idx == 3'd7) frame_cnt <= frame_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_sort_ctrl.sv
// Bench for sort_ctrl: two instances (SETTLE_CYC 1 and 4) with a behavioural sorter beside each.
module tb_sort_ctrl;
    localparam int S0 = 1;
    localparam int S1 = 4;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    logic [1:0]        iv, ordy, irdy, ov, ol, bsy;
    logic [1:0][7:0]   id, od;
    logic [1:0][63:0]  sa, sy;
    logic [1:0][15:0]  fc;

    sort_ctrl_if u_if0();
    sort_ctrl_if u_if1();

    assign u_if0.in_valid  = iv[0];
    assign u_if0.in_data   = id[0];
    assign u_if0.out_ready = ordy[0];
    assign irdy[0] = u_if0.in_ready;
    assign ov[0]   = u_if0.out_valid;
    assign od[0]   = u_if0.out_data;
    assign ol[0]   = u_if0.out_last;

    assign u_if1.in_valid  = iv[1];
    assign u_if1.in_data   = id[1];
    assign u_if1.out_ready = ordy[1];
    assign irdy[1] = u_if1.in_ready;
    assign ov[1]   = u_if1.out_valid;
    assign od[1]   = u_if1.out_data;
    assign ol[1]   = u_if1.out_last;

    sort_ctrl #(.SETTLE_CYC(S0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sif(u_if0.slave),
        .sort_a(sa[0]), .sort_y(sy[0]), .busy(bsy[0]), .frame_cnt(fc[0])
    );
    sort_ctrl #(.SETTLE_CYC(S1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sif(u_if1.slave),
        .sort_a(sa[1]), .sort_y(sy[1]), .busy(bsy[1]), .frame_cnt(fc[1])
    );

    // Sorter model: each byte lands at its rank (ties broken by input position).
    function automatic logic [63:0] sort8(logic [63:0] a);
        logic [63:0] y = '0;
        for (int i = 0; i < 8; i++) begin
            int r = 0;
            for (int j = 0; j < 8; j++)
                if (a[8*j +: 8] < a[8*i +: 8] || (a[8*j +: 8] == a[8*i +: 8] && j < i)) r++;
            y[8*r +: 8] = a[8*i +: 8];
        end
        return y;
    endfunction

    assign sy[0] = sort8(sa[0]);
    assign sy[1] = sort8(sa[1]);

    function automatic bq_t ref_order(bq_t in);
        bq_t q = in;
        q.sort();
`ifdef SORT_CTRL_DESC_EN
        q.reverse();
`endif
        return q;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // gap_mode: 0 none, 1 alternate idle cycles, 2 random idle cycles.
    task automatic send_frame(int s, bq_t b, int gap_mode, output int last_cyc);
        int k = 0;
        int guard = 0;
        bit v;
        logic [63:0] packed_exp = '0;
        bit gap_next = 1'b0;
        last_cyc = cyc;
        while (k < 8 && guard < 200) begin
            guard++;
            case (gap_mode)
                1:       v = gap_next;
                2:       v = ($urandom_range(0, 2) != 0);
                default: v = 1'b1;
            endcase
            gap_next = ~gap_next;
            iv[s] = v;
            id[s] = v ? b[k] : 8'($urandom);
            chk("in_ready_load", 64'(irdy[s]), 64'd1);
            @(posedge clk);
            if (v && irdy[s]) begin
                packed_exp[8*k +: 8] = b[k];
                k++;
            end
            #1;
        end
        iv[s] = 1'b0;
        last_cyc = cyc;
        if (guard >= 200) chk("send_timeout", 64'(k), 64'd8);
        chk("sort_a_packing", sa[s], packed_exp);
    endtask

    // stall_mode: 0 none, 1 five-cycle stall at index 3, 2 random stalls.
    task automatic drain(int s, bq_t exp, int last_cyc, int stall_mode, int abort_at);
        int guard = 0;
        int n;
        ordy[s] = 1'b0;
        @(negedge clk);
        while (!ov[s] && guard < 50) begin
            guard++;
            chk("busy_settle", 64'(bsy[s]), 64'd1);
            chk("in_ready_settle", 64'(irdy[s]), 64'd0);
            @(negedge clk);
        end
        if (!ov[s]) begin
            chk("drain_timeout", 64'(ov[s]), 64'd1);
            return;
        end
        chk("latency", 64'(cyc - last_cyc), 64'(s == 0 ? S0 : S1));
        for (int i = 0; i < 8; i++) begin
            if (i == abort_at) return;
            n = (stall_mode == 1 && i == 3) ? 5 : (stall_mode == 2 ? $urandom_range(0, 2) : 0);
            for (int j = 0; j < n; j++) begin
                ordy[s] = 1'b0;
                chk("stall_valid", 64'(ov[s]), 64'd1);
                chk("stall_data", 64'(od[s]), 64'(exp[i]));
                chk("stall_in_ready", 64'(irdy[s]), 64'd0);
                @(negedge clk);
            end
            ordy[s] = 1'b1;
            chk("out_valid", 64'(ov[s]), 64'd1);
            chk("out_data", 64'(od[s]), 64'(exp[i]));
            chk("out_last", 64'(ol[s]), 64'(i == 7));
            chk("in_ready_drain", 64'(irdy[s]), 64'd0);
            @(negedge clk);
        end
        ordy[s] = 1'b0;
        chk("post_drain_valid", 64'(ov[s]), 64'd0);
        chk("post_drain_in_ready", 64'(irdy[s]), 64'd1);
    endtask

    task automatic run_frame(int s, bq_t b, int gap_mode, int stall_mode, int abort_at);
        int lc;
        send_frame(s, b, gap_mode, lc);
        drain(s, ref_order(b), lc, stall_mode, abort_at);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bq_t f_basic = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4};
        bq_t f_dup   = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h80, 8'h80, 8'h01, 8'h01};
        bq_t f_rnd;
        iv = '0; ordy = '0; id = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_in_ready", 64'(irdy[s]), 64'd1);
            chk("rst_out_valid", 64'(ov[s]), 64'd0);
            chk("rst_out_data", 64'(od[s]), 64'd0);
            chk("rst_out_last", 64'(ol[s]), 64'd0);
            chk("rst_busy", 64'(bsy[s]), 64'd0);
            chk("rst_frame_cnt", 64'(fc[s]), 64'd0);
            chk("rst_sort_a", sa[s], 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(0, f_basic, 0, 0, -1);
        chk("frame_cnt_basic", 64'(fc[0]), 64'd1);
        run_frame(0, f_basic, 0, 1, -1);
        chk("frame_cnt_bp", 64'(fc[0]), 64'd2);
        run_frame(0, f_dup, 1, 0, -1);
        chk("frame_cnt_dup", 64'(fc[0]), 64'd3);

        for (int f = 0; f < 6; f++) begin
            f_rnd = {};
            for (int k = 0; k < 8; k++)
                f_rnd.push_back((f % 2) ? 8'($urandom_range(0, 3)) : 8'($urandom));
            run_frame(0, f_rnd, 2, 2, -1);
        end
        chk("frame_cnt_rand", 64'(fc[0]), 64'd9);

        // Abort in the middle of a drain, with rd_idx at 4.
        run_frame(0, f_basic, 0, 0, 4);
        ordy[0] = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(ov[0]), 64'd0);
        chk("arst_out_data", 64'(od[0]), 64'd0);
        chk("arst_out_last", 64'(ol[0]), 64'd0);
        chk("arst_in_ready", 64'(irdy[0]), 64'd1);
        chk("arst_busy", 64'(bsy[0]), 64'd0);
        chk("arst_frame_cnt", 64'(fc[0]), 64'd0);
        chk("arst_sort_a", sa[0], 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("after_rst_valid", 64'(ov[0]), 64'd0);
            chk("after_rst_in_ready", 64'(irdy[0]), 64'd1);
        end
        chk("after_rst_frame_cnt", 64'(fc[0]), 64'd0);
        ordy[0] = 1'b0;
        run_frame(0, f_dup, 0, 0, -1);
        chk("frame_cnt_after_rst", 64'(fc[0]), 64'd1);

        // Longer settle, back-to-back frames with no idle between them.
        run_frame(1, f_basic, 0, 0, -1);
        run_frame(1, f_dup, 0, 0, -1);
        chk("frame_cnt_b2b", 64'(fc[1]), 64'd2);
        for (int f = 0; f < 3; f++) begin
            f_rnd = {};
            for (int k = 0; k < 8; k++) f_rnd.push_back(8'($urandom));
            run_frame(1, f_rnd, 2, 2, -1);
        end
        chk("frame_cnt_s4", 64'(fc[1]), 64'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
